// File: rtl/fsk4_mod.sv
// 4FSK baseband modulator: bytes split into four MSB-first dibits, each dibit
// selects a frequency word driving a continuous-phase NCO into a 64-entry sine ROM.
module fsk4_mod #(
  parameter int ACC_W   = 16,
  parameter int SYM_DIV = 128,
  parameter int FREQ0   = 512,
  parameter int FREQ1   = 1024,
  parameter int FREQ2   = 1536,
  parameter int FREQ3   = 2048
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic signed [7:0] sin_out,
  output logic [1:0]        sym_out,
  output logic              sym_strobe,
  output logic              busy
);
  localparam int CNT_W = $clog2(SYM_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_DIV - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q;
  logic [ACC_W-1:0]    acc_q, fw_q;
  logic [CNT_W-1:0]    sym_cnt_q;
  logic [1:0]          dib_idx_q, sym_q;
  logic [7:0]          shift_q;
  logic signed [7:0]   sin_q;
  logic                strobe_q;
  logic                last_d, accept_d;
  logic [1:0]          nxt_dib_d;

  function automatic logic [ACC_W-1:0] fw_of(input logic [1:0] d);
    logic [ACC_W-1:0] f;
    case (d)
      2'd0:    f = ACC_W'(FREQ0);
      2'd1:    f = ACC_W'(FREQ1);
      2'd2:    f = ACC_W'(FREQ2);
      default: f = ACC_W'(FREQ3);
    endcase
    return f;
  endfunction

  // Quarter-wave table of round(127*sin(2*pi*k/64)); other quadrants by mirror/negate.
  function automatic logic signed [7:0] sine(input logic [5:0] k);
    logic [4:0] idx;
    logic [7:0] mag;
    idx = k[4] ? (5'd16 - {1'b0, k[3:0]}) : {1'b0, k[3:0]};
    case (idx)
      5'd0:    mag = 8'd0;
      5'd1:    mag = 8'd12;
      5'd2:    mag = 8'd25;
      5'd3:    mag = 8'd37;
      5'd4:    mag = 8'd49;
      5'd5:    mag = 8'd60;
      5'd6:    mag = 8'd71;
      5'd7:    mag = 8'd81;
      5'd8:    mag = 8'd90;
      5'd9:    mag = 8'd98;
      5'd10:   mag = 8'd106;
      5'd11:   mag = 8'd112;
      5'd12:   mag = 8'd117;
      5'd13:   mag = 8'd122;
      5'd14:   mag = 8'd125;
      5'd15:   mag = 8'd126;
      5'd16:   mag = 8'd127;
      default: mag = 8'd0;
    endcase
    return k[5] ? -mag : mag;
  endfunction

  assign last_d     = (dib_idx_q == 2'd3) && (sym_cnt_q == CNT_LAST);
  assign data_ready = (state_q == IDLE) || last_d;
  assign accept_d   = data_valid && data_ready;
  assign nxt_dib_d  = shift_q[5:4];
  assign busy       = (state_q == SEND);
  assign sin_out    = sin_q;
  assign sym_out    = sym_q;
  assign sym_strobe = strobe_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      fw_q      <= '0;
      sym_cnt_q <= '0;
      dib_idx_q <= 2'd0;
      sym_q     <= 2'd0;
      shift_q   <= 8'd0;
      sin_q     <= 8'sd0;
      strobe_q  <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      if (state_q == IDLE) begin
        sin_q <= 8'sd0;
      end else begin
        // ROM sees the pre-increment phase; acc is never cleared, keeping phase continuous.
        sin_q     <= sine(acc_q[ACC_W-1 -: 6]);
        acc_q     <= acc_q + fw_q;
        sym_cnt_q <= sym_cnt_q + CNT_W'(1);
        if (sym_cnt_q == CNT_LAST) begin
          sym_cnt_q <= '0;
          if (dib_idx_q != 2'd3) begin
            dib_idx_q <= dib_idx_q + 2'd1;
            shift_q   <= shift_q << 2;
            fw_q      <= fw_of(nxt_dib_d);
            sym_q     <= nxt_dib_d;
            strobe_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
      end
      // A new byte overrides the end-of-byte return to IDLE, giving gapless back-to-back bytes.
      if (accept_d) begin
        shift_q   <= data_in;
        fw_q      <= fw_of(data_in[7:6]);
        sym_q     <= data_in[7:6];
        sym_cnt_q <= '0;
        dib_idx_q <= 2'd0;
        strobe_q  <= 1'b1;
        state_q   <= SEND;
      end
    end
  end
endmodule

// File: tb/tb_fsk4_mod.sv
// Bench for fsk4_mod: directed plan steps plus random bytes, every cycle checked
// against a symbol-queue / phase model with a $sin-derived table.
module tb_fsk4_mod;
  localparam int SD = 64;
  localparam int FW [4] = '{256, 512, 768, 1024};

  logic              clk, rst, valid;
  logic [7:0]        din;
  logic              data_ready, sym_strobe, busy;
  logic signed [7:0] sin_out;
  logic [1:0]        sym_out;

  int checks = 0, errors = 0;
  bit primed = 0;

  // reference model state
  bit m_busy = 0;
  int m_phase = 0, m_sym = 0, m_left = 0, exp_sin = 0;
  bit exp_strobe = 0;
  int m_pend[$];

  fsk4_mod #(.ACC_W(16), .SYM_DIV(SD), .FREQ0(FW[0]), .FREQ1(FW[1]),
             .FREQ2(FW[2]), .FREQ3(FW[3])) dut (
    .clk(clk), .reset(rst), .data_in(din), .data_valid(valid),
    .data_ready(data_ready), .sin_out(sin_out), .sym_out(sym_out),
    .sym_strobe(sym_strobe), .busy(busy));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, want);
    end
  endtask

  function automatic int lut(int k);
    real r;
    r = 127.0 * $sin(2.0 * 3.14159265358979 * k / 64.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  function automatic bit model_ready();
    return !m_busy || (m_pend.size() == 0 && m_left == 1);
  endfunction

  task automatic model_edge(input bit r, input bit v, input logic [7:0] d, input bit rdy);
    if (r) begin
      m_busy = 0; m_phase = 0; m_sym = 0; m_left = 0; m_pend.delete();
      exp_sin = 0; exp_strobe = 0;
    end else begin
      exp_strobe = 0;
      if (m_busy) begin
        exp_sin = lut(m_phase / 1024);
        m_phase = (m_phase + FW[m_sym]) % 65536;
        m_left--;
        if (m_left == 0) begin
          if (m_pend.size() > 0) begin
            m_sym = m_pend.pop_front(); m_left = SD; exp_strobe = 1;
          end else m_busy = 0;
        end
      end else exp_sin = 0;
      if (v && rdy) begin
        m_sym = int'(d[7:6]);
        m_pend.delete();
        m_pend.push_back(int'(d[5:4]));
        m_pend.push_back(int'(d[3:2]));
        m_pend.push_back(int'(d[1:0]));
        m_left = SD; m_busy = 1; exp_strobe = 1;
      end
    end
  endtask

  task automatic step(output bit accepted);
    bit rdy;
    rdy = model_ready();
    if (primed) chk("ready", data_ready, rdy);
    accepted = !rst && valid && rdy;
    @(posedge clk); #1;
    model_edge(rst, valid, din, rdy);
    primed = 1;
    chk("busy", busy, m_busy);
    chk("sin", sin_out, exp_sin);
    chk("sym", sym_out, m_sym);
    chk("strobe", sym_strobe, exp_strobe);
  endtask

  task automatic run(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send(input logic [7:0] b);
    bit a;
    int n;
    valid = 1; din = b; a = 0; n = 0;
    while (!a && n < 600) begin step(a); n++; end
    valid = 0;
    chk("accept_wait", a, 1);
  endtask

  initial begin
    bit a;
    int second, brun;
    bit broke;
    logic [7:0] b;
    logic [1:0] s_at [4];

    // 1: reset with valid high
    rst = 1; valid = 1; din = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      step(a);
      chk("t1_ready", data_ready, 1);
      chk("t1_busy", busy, 0);
      chk("t1_sin", sin_out, 0);
    end
    rst = 0; valid = 0;
    run(1);

    // 2: byte 0x1B, symbol timing
    send(8'h1B);
    for (int i = 0; i <= 260; i++) begin
      if (i > 0) step(a);
      if (i % SD == 0 && i < 4 * SD) begin
        chk("t2_sym", sym_out, i / SD);
        chk("t2_strobe_on", sym_strobe, 1);
      end
      if (i == 1 || i == 63 || i == 200) chk("t2_strobe_off", sym_strobe, 0);
      if (i == 255) chk("t2_busy_hi", busy, 1);
      if (i == 256) chk("t2_busy_lo", busy, 0);
    end

    // 3: byte 0xFF from phase 0, 64-cycle sine period
    rst = 1; run(1); rst = 0;
    send(8'hFF);
    for (int i = 1; i <= 260; i++) begin
      step(a);
      if (i == 1)  chk("t3_s0", sin_out, 0);
      if (i == 2)  chk("t3_s1", sin_out, 12);
      if (i == 3)  chk("t3_s2", sin_out, 25);
      if (i == 17) chk("t3_peak", sin_out, 127);
      if (i == 49) chk("t3_trough", sin_out, -127);
    end

    // 4: back-to-back 0x00 then 0xFF with valid held
    send(8'h00);
    valid = 1; din = 8'hFF;
    second = -1; brun = 1; broke = 0;
    for (int i = 1; i <= 530; i++) begin
      step(a);
      if (a) begin second = i; valid = 0; end
      if (busy && !broke) brun++;
      else broke = 1;
    end
    valid = 0;
    chk("t4_second_accept", second, 4 * SD);
    chk("t4_busy_run", brun, 8 * SD);

    // 5: reset mid-byte, then clean restart with 0x40
    send(8'($urandom));
    run(100);
    rst = 1; run(1);
    chk("t5_busy", busy, 0);
    chk("t5_sin", sin_out, 0);
    chk("t5_sym", sym_out, 0);
    rst = 0;
    send(8'h40);
    chk("t5_new_sym", sym_out, 1);
    chk("t5_new_strobe", sym_strobe, 1);
    run(4 * SD + 4);

    // 6: valid pulsed mid-symbol while busy is ignored
    b = 8'($urandom);
    s_at[0] = b[7:6]; s_at[1] = b[5:4]; s_at[2] = b[3:2]; s_at[3] = b[1:0];
    send(b);
    for (int i = 0; i <= 260; i++) begin
      if (i == 30) begin
        valid = 1; din = ~b;
        chk("t6_ready", data_ready, 0);
      end
      if (i > 0) step(a);
      valid = 0;
      if (i % SD == 0 && i < 4 * SD) chk("t6_sym", sym_out, s_at[i / SD]);
      if (i == 256) chk("t6_idle", busy, 0);
    end

    // random bytes with random gaps, some back-to-back
    for (int n = 0; n < 6; n++) begin
      run($urandom_range(0, 3));
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        valid = 1; din = 8'($urandom);
        for (int i = 0; i < 4 * SD && valid; i++) begin
          step(a);
          if (a) valid = 0;
        end
        valid = 0;
      end
    end
    run(4 * SD + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
